// File: rtl/rsa_pkg.sv
// RSA_pkg: shared RSA types and constants.
//   MOD_WIDTH      - width of msg, key and modulus
//   WORD_WIDTH     - width of one word on the loader input stream
//   KeyType        - one MOD_WIDTH operand
//   RSAModIn       - {msg, key, modulus} record consumed by the RSA core
//   loader_state_t - rsa_in_loader state encoding
package RSA_pkg;

    localparam int MOD_WIDTH  = 256;
    localparam int WORD_WIDTH = 32;

    typedef logic [MOD_WIDTH-1:0] KeyType;

    typedef struct packed {
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RSAModIn;

    typedef enum logic {
        LD_COLLECT = 1'b0,
        LD_SEND    = 1'b1
    } loader_state_t;

endpackage

// File: rtl/rsa_in_loader.sv
// rsa_in_loader: assembles a stream of WORD_WIDTH words into one RSAModIn
// record ({msg, key, modulus}) for the RSA core.
// Word order: all msg words, then key, then modulus; least-significant word
// of each field first.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous reset, active-low
//   i_valid - upstream word valid
//   i_ready - loader can accept a word this cycle
//   i_word  - upstream data word
//   o_valid - assembled record valid toward the RSA core
//   o_ready - RSA core accepts the record
//   o_out   - assembled record
// WORD_WIDTH must divide MOD_WIDTH exactly.
module rsa_in_loader
    import RSA_pkg::*;
#(
    parameter int WORD_WIDTH = RSA_pkg::WORD_WIDTH,
    parameter int MOD_WIDTH  = RSA_pkg::MOD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [WORD_WIDTH-1:0] i_word,
    output logic                  o_valid,
    input  logic                  o_ready,
    output RSAModIn               o_out
);

    localparam int WPF   = MOD_WIDTH / WORD_WIDTH;  // words per field
    localparam int N     = 3 * WPF;                 // words per record
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    loader_state_t         state;
    loader_state_t         state_next;
    logic [CNT_W-1:0]      cnt;
    logic [WORD_WIDTH-1:0] words [N];
    logic [3*MOD_WIDTH-1:0] flat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LD_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // i_ready and o_valid depend only on the registered state, so o_ready
    // never reaches i_ready combinationally.
    always_comb begin
        state_next = state;
        i_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            LD_COLLECT: begin
                i_ready = 1'b1;
                if (i_valid && (cnt == LAST)) begin
                    state_next = LD_SEND;
                end
            end
            LD_SEND: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_next = LD_COLLECT;
                end
            end
            default: state_next = LD_COLLECT;
        endcase
    end

    // Slots are not cleared between records; every slot is rewritten before
    // the next record is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int i = 0; i < N; i++) begin
                words[i] <= '0;
            end
        end else if (i_valid && i_ready) begin
            words[cnt] <= i_word;
            cnt        <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Stream slot g is word (g % WPF) of field (g / WPF); field 0 (msg) sits
    // in the most significant third of the packed record.
    for (genvar g = 0; g < N; g++) begin : g_slot
        localparam int F = g / WPF;
        localparam int K = g % WPF;
        assign flat[(2 - F) * MOD_WIDTH + K * WORD_WIDTH +: WORD_WIDTH] = words[g];
    end

    assign o_out = RSAModIn'(flat);

endmodule

// File: tb/tb_rsa_in_loader.sv
module tb_rsa_in_loader;
    import RSA_pkg::*;

    localparam int W   = 32;
    localparam int WPF = 256 / W;
    localparam int N   = 3 * WPF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready;
    logic [W-1:0] i_word = '0;
    logic         o_valid;
    logic         o_ready = 1'b0;
    RSAModIn      o_out;

    rsa_in_loader #(.WORD_WIDTH(W), .MOD_WIDTH(256)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_word (i_word),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_out  (o_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [767:0] got, input logic [767:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic RSAModIn build(input logic [W-1:0] q[$]);
        RSAModIn r;
        r = '0;
        for (int i = 0; i < q.size(); i++) begin
            KeyType part;
            part = KeyType'(q[i]) << (W * (i % WPF));
            if (i / WPF == 0)      r.msg     = r.msg | part;
            else if (i / WPF == 1) r.key     = r.key | part;
            else                   r.modulus = r.modulus | part;
        end
        return r;
    endfunction

    logic [W-1:0] mq[$];
    bit           m_send = 0;
    RSAModIn      m_rec  = '0;
    bit           mon_en = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_send = 0;
            m_rec  = '0;
        end else if (!m_send) begin
            if (i_valid) begin
                mq.push_back(i_word);
                if (mq.size() == N) begin
                    m_rec = build(mq);
                    mq.delete();
                    m_send = 1;
                end
            end
        end else if (o_ready) begin
            m_send = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst) begin
                chk("rst_i_ready", i_ready, 1'b1);
                chk("rst_o_valid", o_valid, 1'b0);
                chk("rst_o_out", o_out, '0);
            end else begin
                chk("i_ready", i_ready, !m_send);
                chk("o_valid", o_valid, m_send);
                if (m_send) chk("o_out", o_out, m_rec);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap_pct);
        int guard;
        bit rdy;
        guard = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            i_valid = 1'b0;
            i_word  = $urandom;
            tick();
        end
        i_valid = 1'b1;
        i_word  = w;
        forever begin
            rdy = i_ready;
            tick();
            if (rdy) break;
            guard++;
            if (guard > 100) begin
                fail_now("word_accept");
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic send_record(input logic [W-1:0] ws [N], input int gap_pct);
        for (int i = 0; i < N; i++) send_word(ws[i], gap_pct);
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            if (o_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) fail_now(name);
    endtask

    task automatic handshake();
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ws [N];
        RSAModIn      hold;
        RSAModIn      ref_rec;

        rst    = 1'b0;
        mon_en = 1'b1;
        tick();
        tick();
        chk("reset_o_valid", o_valid, 1'b0);
        chk("reset_i_ready", i_ready, 1'b1);
        chk("reset_o_out", o_out, '0);
        rst = 1'b1;
        tick();

        // back-to-back 1..24 with o_ready held high during collection
        for (int i = 0; i < N; i++) ws[i] = W'(i + 1);
        o_ready = 1'b1;
        send_record(ws, 0);
        chk("latency_o_valid", o_valid, 1'b1);
        chk("b2b_msg_w0", o_out.msg[31:0], 32'h1);
        chk("b2b_key_w0", o_out.key[31:0], 32'h9);
        chk("b2b_mod_w7", o_out.modulus[255:224], 32'h18);
        chk("b2b_msg_w7", o_out.msg[255:224], 32'h8);
        tick();
        o_ready = 1'b0;
        chk("b2b_ready_after", i_ready, 1'b1);

        // backpressure with ignored extra words
        for (int i = 0; i < N; i++) ws[i] = $urandom;
        send_record(ws, 0);
        wait_valid("bp_valid");
        hold = o_out;
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1;
            i_word  = $urandom;
            tick();
            chk("bp_stable", o_out, hold);
            chk("bp_o_valid", o_valid, 1'b1);
            chk("bp_i_ready", i_ready, 1'b0);
        end
        i_valid = 1'b0;
        handshake();
        chk("bp_ready_next", i_ready, 1'b1);
        chk("bp_valid_drop", o_valid, 1'b0);

        // bubbles: same words gap-free and with 50% gaps
        for (int i = 0; i < N; i++) ws[i] = $urandom;
        send_record(ws, 0);
        wait_valid("nogap_valid");
        ref_rec = o_out;
        handshake();
        send_record(ws, 50);
        wait_valid("gap_valid");
        chk("bubble_same", o_out, ref_rec);
        repeat ($urandom_range(3)) tick();
        handshake();

        // reset after word 13
        for (int i = 0; i < 13; i++) send_word($urandom, 20);
        rst = 1'b0;
        tick();
        chk("midrst_o_valid", o_valid, 1'b0);
        chk("midrst_o_out", o_out, '0);
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < N; i++) ws[i] = $urandom;
        send_record(ws, 0);
        wait_valid("midrst_valid");
        chk("midrst_msg_w0", o_out.msg[31:0], ws[0]);
        chk("midrst_mod_w7", o_out.modulus[255:224], ws[N-1]);
        handshake();

        // two records with distinct patterns
        for (int i = 0; i < N; i++) ws[i] = 32'hA5A5_0000 | W'(i);
        send_record(ws, 30);
        wait_valid("pat_a_valid");
        handshake();
        for (int i = 0; i < N; i++) ws[i] = 32'h5A5A_0000 | W'(i);
        send_record(ws, 30);
        wait_valid("pat_b_valid");
        begin
            logic [767:0] flat;
            flat = o_out;
            for (int j = 0; j < N; j++) chk("pat_b_upper", flat[j*32+16 +: 16], 16'h5A5A);
        end
        handshake();
        tick();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
